hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage CPU. Sits beside the forwarding logic.
- Detects load-use hazards and inserts one bubble.
- Flushes IF/ID on a taken branch.
- Freezes the whole pipeline while an EX/MEM data-memory access waits for acknowledge, with a timeout/abort path.

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubble, taken-branch flush, data-memory wait freeze
// with timeout abort. Define HAZARD_CTRL_PERF_EN to add the stall/bubble performance counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  IF_ID_RSaddr_i,
  input  logic [4:0]  IF_ID_RTaddr_i,
  input  logic [4:0]  ID_EX_RTaddr_i,
  input  logic        ID_EX_MemRead_i,
  input  logic        branch_taken_i,
  input  logic        EX_MEM_MemRead_i,
  input  logic        EX_MEM_MemWrite_i,
  input  logic        dmem_ack_i,
  output logic        dmem_req_o,
  output logic        PC_write_o,
  output logic        IF_ID_write_o,
  output logic        ID_EX_bubble_o,
  output logic        IF_ID_flush_o,
  output logic        freeze_o,
  output logic        mem_err_o
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cyc_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {StRun, StMemWait, StAbort} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             mem_err_q;
  logic             access;
  logic             lu;

  assign access = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;
  assign lu     = ID_EX_MemRead_i && (ID_EX_RTaddr_i != 5'd0) &&
                  ((ID_EX_RTaddr_i == IF_ID_RSaddr_i) || (ID_EX_RTaddr_i == IF_ID_RTaddr_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (access && !dmem_ack_i) begin
            state_q    <= StMemWait;
            wait_cnt_q <= CNT_W'(1);
          end
        end
        StMemWait: begin
          if (dmem_ack_i) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_q   <= StAbort;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        StAbort: begin
          // One cycle with the pipeline released so the hung access drains out of MEM.
          state_q    <= StRun;
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= StRun;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    freeze_o   = 1'b0;
    dmem_req_o = 1'b0;
    case (state_q)
      StRun: begin
        freeze_o   = access & ~dmem_ack_i;
        dmem_req_o = access;
      end
      StMemWait: begin
        freeze_o   = ~dmem_ack_i;
        dmem_req_o = access;
      end
      default: begin
        freeze_o   = 1'b0;
        dmem_req_o = 1'b0;
      end
    endcase
  end

  // Freeze dominates the bubble, which dominates the flush; a held branch is seen again later.
  always_comb begin
    PC_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    ID_EX_bubble_o = 1'b0;
    IF_ID_flush_o  = 1'b0;
    if (freeze_o) begin
      PC_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
    end else if (lu) begin
      PC_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      ID_EX_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      IF_ID_flush_o = 1'b1;
    end
  end

  assign mem_err_o = mem_err_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cyc_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cyc_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (freeze_o && (stall_cyc_q != 32'hFFFF_FFFF)) begin
        stall_cyc_q <= stall_cyc_q + 32'd1;
      end
      if (ID_EX_bubble_o && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cyc_o  = stall_cyc_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge, outputs are checked 1ns later.
// Output vector order: {dmem_req, PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, freeze, mem_err}.
module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] IF_ID_RSaddr_i = '0;
  logic [4:0] IF_ID_RTaddr_i = '0;
  logic [4:0] ID_EX_RTaddr_i = '0;
  logic       ID_EX_MemRead_i = 1'b0;
  logic       branch_taken_i = 1'b0;
  logic       EX_MEM_MemRead_i = 1'b0;
  logic       EX_MEM_MemWrite_i = 1'b0;
  logic       dmem_ack_i = 1'b0;
  logic       dmem_req_o, PC_write_o, IF_ID_write_o, ID_EX_bubble_o;
  logic       IF_ID_flush_o, freeze_o, mem_err_o;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cyc_o, bubble_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [6:0] obs;

  localparam logic [6:0] Idle    = 7'b0110000;
  localparam logic [6:0] Frozen  = 7'b1000010;
  localparam logic [6:0] Bubble  = 7'b0001000;
  localparam logic [6:0] AckGo   = 7'b1110000;

  hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .IF_ID_RSaddr_i    (IF_ID_RSaddr_i),
    .IF_ID_RTaddr_i    (IF_ID_RTaddr_i),
    .ID_EX_RTaddr_i    (ID_EX_RTaddr_i),
    .ID_EX_MemRead_i   (ID_EX_MemRead_i),
    .branch_taken_i    (branch_taken_i),
    .EX_MEM_MemRead_i  (EX_MEM_MemRead_i),
    .EX_MEM_MemWrite_i (EX_MEM_MemWrite_i),
    .dmem_ack_i        (dmem_ack_i),
    .dmem_req_o        (dmem_req_o),
    .PC_write_o        (PC_write_o),
    .IF_ID_write_o     (IF_ID_write_o),
    .ID_EX_bubble_o    (ID_EX_bubble_o),
    .IF_ID_flush_o     (IF_ID_flush_o),
    .freeze_o          (freeze_o),
    .mem_err_o         (mem_err_o)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .stall_cyc_o       (stall_cyc_o),
    .bubble_cnt_o      (bubble_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [6:0] outs();
    return {dmem_req_o, PC_write_o, IF_ID_write_o, ID_EX_bubble_o, IF_ID_flush_o, freeze_o,
            mem_err_o};
  endfunction

  // Apply one cycle's inputs on the falling edge and let the combinational outputs settle.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                       input logic ex_rd, input logic br, input logic mrd, input logic mwr,
                       input logic ack);
    @(negedge clk_i);
    IF_ID_RSaddr_i    = rs;
    IF_ID_RTaddr_i    = rt;
    ID_EX_RTaddr_i    = ex_rt;
    ID_EX_MemRead_i   = ex_rd;
    branch_taken_i    = br;
    EX_MEM_MemRead_i  = mrd;
    EX_MEM_MemWrite_i = mwr;
    dmem_ack_i        = ack;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    obs = outs(); checks++;
    if (obs !== Frozen) begin errors++; $display("FAIL reset_pre_wait got %b want %b", obs, Frozen); end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #2;
    rst_i = 1'b0;
    EX_MEM_MemRead_i = 1'b0;
    #1;
    obs = outs(); checks++;
    if (obs !== Idle) begin errors++; $display("FAIL reset_async got %b want %b", obs, Idle); end
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== Idle) begin errors++; $display("FAIL reset_release got %b want %b", obs, Idle); end
    // Back in RUN: a fresh unacked access freezes at once and MEM_WAIT keeps it frozen.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      obs = outs(); checks++;
      if (obs !== Frozen) begin errors++; $display("FAIL reset_reenter[%0d] got %b want %b", i, obs, Frozen); end
    end
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    obs = outs(); checks++;
    if (obs !== AckGo) begin errors++; $display("FAIL reset_reenter_ack got %b want %b", obs, AckGo); end
  endtask

  task automatic test_load_use();
    drive(5, 0, 5, 1, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== Bubble) begin errors++; $display("FAIL lu_rs got %b want %b", obs, Bubble); end
    drive(5, 0, 5, 0, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== Idle) begin errors++; $display("FAIL lu_gone got %b want %b", obs, Idle); end
    drive(1, 7, 7, 1, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== Bubble) begin errors++; $display("FAIL lu_rt got %b want %b", obs, Bubble); end
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== Idle) begin errors++; $display("FAIL lu_r0 got %b want %b", obs, Idle); end
    drive(3, 4, 9, 1, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== Idle) begin errors++; $display("FAIL lu_nomatch got %b want %b", obs, Idle); end
  endtask

  task automatic test_zero_wait();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    obs = outs(); checks++;
    if (obs !== AckGo) begin errors++; $display("FAIL zw_store got %b want %b", obs, AckGo); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== Idle) begin errors++; $display("FAIL zw_after got %b want %b", obs, Idle); end
  endtask

  task automatic test_wait_ack();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      obs = outs(); checks++;
      if (obs !== Frozen) begin errors++; $display("FAIL wait[%0d] got %b want %b", i, obs, Frozen); end
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    obs = outs(); checks++;
    if (obs !== AckGo) begin errors++; $display("FAIL wait_ack got %b want %b", obs, AckGo); end
    // A lingering MEM_WAIT would freeze here even with no access.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== Idle) begin errors++; $display("FAIL wait_run got %b want %b", obs, Idle); end
  endtask

  task automatic test_branch_freeze();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 1, 0, 0);
      obs = outs(); checks++;
      if (obs !== Frozen) begin errors++; $display("FAIL br_frozen[%0d] got %b want %b", i, obs, Frozen); end
    end
    drive(0, 0, 0, 0, 1, 1, 0, 1);
    obs = outs(); checks++;
    if (obs !== 7'b1110100) begin errors++; $display("FAIL br_unfreeze got %b want %b", obs, 7'b1110100); end
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== 7'b0110100) begin errors++; $display("FAIL br_plain got %b want %b", obs, 7'b0110100); end
  endtask

  task automatic test_branch_lu();
    drive(0, 3, 3, 1, 1, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== Bubble) begin errors++; $display("FAIL br_lu got %b want %b", obs, Bubble); end
    drive(0, 3, 3, 0, 1, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== 7'b0110100) begin errors++; $display("FAIL br_lu_next got %b want %b", obs, 7'b0110100); end
  endtask

  task automatic test_timeout();
    // One RUN detect cycle plus 15 MEM_WAIT cycles (counter 1..15) are frozen.
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      obs = outs(); checks++;
      if (obs !== Frozen) begin errors++; $display("FAIL to_wait[%0d] got %b want %b", i, obs, Frozen); end
    end
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    obs = outs(); checks++;
    if (obs !== 7'b0110001) begin errors++; $display("FAIL to_abort got %b want %b", obs, 7'b0110001); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== 7'b0110001) begin errors++; $display("FAIL to_sticky got %b want %b", obs, 7'b0110001); end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    obs = outs(); checks++;
    if (obs !== 7'b1000011) begin errors++; $display("FAIL to_rerun got %b want %b", obs, 7'b1000011); end
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    obs = outs(); checks++;
    if (obs !== 7'b1110001) begin errors++; $display("FAIL to_reack got %b want %b", obs, 7'b1110001); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== 7'b0110001) begin errors++; $display("FAIL to_idle got %b want %b", obs, 7'b0110001); end
  endtask

  task automatic test_reset_clears_err();
    #2;
    rst_i = 1'b0;
    #1;
    obs = outs(); checks++;
    if (obs !== Idle) begin errors++; $display("FAIL err_reset got %b want %b", obs, Idle); end
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    obs = outs(); checks++;
    if (obs !== Idle) begin errors++; $display("FAIL err_release got %b want %b", obs, Idle); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_wait();
    test_wait_ack();
    test_branch_freeze();
    test_branch_lu();
    test_timeout();
    test_reset_clears_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
